// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step generator.
// Optional position counter is enabled by defining QUAD_POS_EN.
package quad_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

    // Phase index 0..3 walks the Gray sequence in the "up" direction
    typedef logic [1:0] phase_t;

    // Phase index -> {A,B}: 0->00, 1->10, 2->11, 3->01
    localparam logic [7:0] PhaseAbMap = 8'b01_11_10_00;

    // Direction encoding of cmd_dir
    localparam logic DirUp   = 1'b1;
    localparam logic DirDown = 1'b0;

    function automatic logic [1:0] phase_to_ab(input phase_t p);
        return PhaseAbMap[{p, 1'b0} +: 2];
    endfunction

    function automatic phase_t phase_step(input phase_t p, input logic dir);
        return (dir == DirUp) ? p + 2'd1 : p - 2'd1;
    endfunction

endpackage

// File: rtl/quad_step_gen_if.sv
// Command/status bundle between a stimulus master and quad_step_gen.
// The pos signal exists only when QUAD_POS_EN is defined.
interface quad_step_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
`ifdef QUAD_POS_EN
    ,
    parameter int unsigned POS_W = 12
`endif
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_half_period;
    logic             abort;
    logic             quad_A;
    logic             quad_B;
    logic             busy;
    logic             done;
`ifdef QUAD_POS_EN
    logic [POS_W-1:0] pos;
`endif

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_half_period, abort,
        input  cmd_ready, quad_A, quad_B, busy, done
`ifdef QUAD_POS_EN
        , pos
`endif
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_half_period, abort,
        output cmd_ready, quad_A, quad_B, busy, done
`ifdef QUAD_POS_EN
        , pos
`endif
    );

endinterface

// File: rtl/quad_tick_div.sv
// Loadable down-counter: pulses tick when it reaches zero while enabled,
// then reloads the last loaded value.
module quad_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_q, reload_d;

    // Next-state: load takes priority, otherwise count down and wrap to reload
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            reload_d = load_val_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
        end
    end

    // Counter and reload registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature A/B stimulus generator driven by step commands.
// Define QUAD_POS_EN to add the signed detent position counter.
module quad_step_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
`ifdef QUAD_POS_EN
    ,
    parameter int unsigned POS_W = 12
`endif
) (
    input logic            clk,
    input logic            rst,
    quad_step_gen_if.slave bus
);
    import quad_pkg::*;

    localparam int unsigned EdgeW = CNT_W + 2;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [EdgeW-1:0] edges_q, edges_d;
    phase_t           phase_q, phase_d;
    logic [1:0]       ab_q, ab_d;
    logic             accept;
    logic             tick;
    logic             last_edge;
    logic [DIV_W-1:0] div_load_val;
`ifdef QUAD_POS_EN
    logic [POS_W-1:0] pos_q, pos_d;
`endif

    assign accept       = (state_q == StIdle) && bus.cmd_valid;
    assign last_edge    = (edges_q == EdgeW'(1));
    // A half period of 0 behaves as 1, i.e. a reload value of 0
    assign div_load_val = (bus.cmd_half_period == '0) ? '0
                                                      : bus.cmd_half_period - DIV_W'(1);

    quad_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (div_load_val),
        .en_i       (state_q == StRun),
        .tick_o     (tick)
    );

    // FSM, edge counting and phase advance
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        edges_d = edges_q;
        phase_d = phase_q;
`ifdef QUAD_POS_EN
        pos_d   = pos_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    dir_d   = bus.cmd_dir;
                    edges_d = {bus.cmd_steps, 2'b00};
                    state_d = (bus.cmd_steps == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // The final edge wins over a coincident abort
                if (tick && (!bus.abort || last_edge)) begin
                    phase_d = phase_step(phase_q, dir_q);
                    edges_d = edges_q - EdgeW'(1);
                    if (last_edge) begin
                        state_d = StDone;
                    end
`ifdef QUAD_POS_EN
                    // Remaining count ending in 01 means this edge closes a detent
                    if (edges_q[1:0] == 2'b01) begin
                        pos_d = (dir_q == DirUp) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    end
`endif
                end else if (bus.abort) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        ab_d = phase_to_ab(phase_d);
    end

    // State registers; A/B come straight from ab_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dir_q   <= DirUp;
            edges_q <= '0;
            phase_q <= '0;
            ab_q    <= 2'b00;
`ifdef QUAD_POS_EN
            pos_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            edges_q <= edges_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
`ifdef QUAD_POS_EN
            pos_q   <= pos_d;
`endif
        end
    end

    assign bus.quad_A    = ab_q[1];
    assign bus.quad_B    = ab_q[0];
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
`ifdef QUAD_POS_EN
    assign bus.pos       = pos_q;
`endif

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: directed literal checks plus a
// cycle-level behavioural model compared on every falling edge.
module tb_quad_step_gen;

    localparam int CNT_W = 8;
    localparam int DIV_W = 16;
    localparam int POS_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_step_gen_if bus ();

    quad_step_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: edge k of a command lands exactly k*hp cycles after acceptance
    logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int   cyc     = 0;
    int   m_mode  = 0;  // 0 waiting for command, 1 stepping, 2 completion cycle
    int   m_t0    = 0;
    int   m_hp    = 1;
    int   m_total = 0;
    int   m_n     = 0;
    int   m_phase = 0;
    int   m_pos   = 0;
    logic m_dir   = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  = 0;
            m_phase = 0;
            m_pos   = 0;
        end else begin
            cyc++;
            case (m_mode)
                0: begin
                    if (bus.cmd_valid) begin
                        m_t0    = cyc;
                        m_hp    = (bus.cmd_half_period == 0) ? 1 : int'(bus.cmd_half_period);
                        m_total = 4 * int'(bus.cmd_steps);
                        m_n     = 0;
                        m_dir   = bus.cmd_dir;
                        m_mode  = (m_total == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if ((cyc - m_t0) == (m_n + 1) * m_hp &&
                        (!bus.abort || (m_n + 1) == m_total)) begin
                        m_n++;
                        m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
                        if (m_n % 4 == 0) m_pos += m_dir ? 1 : -1;
                        if (m_n == m_total) m_mode = 2;
                    end else if (bus.abort) begin
                        m_mode = 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (rst && model_on) begin
            logic [1:0] exp_ab;
            exp_ab = ab_tab[m_phase];
            chk("model_A", bus.quad_A, exp_ab[1]);
            chk("model_B", bus.quad_B, exp_ab[0]);
            chk("model_busy", bus.busy, m_mode == 1);
            chk("model_done", bus.done, m_mode == 2);
            chk("model_ready", bus.cmd_ready, m_mode == 0);
`ifdef QUAD_POS_EN
            chk("model_pos", bus.pos, POS_W'(m_pos));
`endif
        end
    end

    // Present a command and return half a cycle after the accepting edge
    task automatic send(input logic d, input int s, input int h);
        int k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_ready) chk("accept_timeout", 0, 1);
        bus.cmd_valid       = 1'b1;
        bus.cmd_dir         = d;
        bus.cmd_steps       = CNT_W'(s);
        bus.cmd_half_period = DIV_W'(h);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid       = 1'b0;
        bus.cmd_dir         = ~d;
        bus.cmd_steps       = CNT_W'($urandom);
        bus.cmd_half_period = DIV_W'($urandom);
    endtask

    function automatic logic [1:0] ab();
        return {bus.quad_A, bus.quad_B};
    endfunction

    initial begin
        bus.cmd_valid       = 1'b0;
        bus.cmd_dir         = 1'b0;
        bus.cmd_steps       = '0;
        bus.cmd_half_period = '0;
        bus.abort           = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ab", ab(), 2'b00);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
`ifdef QUAD_POS_EN
        chk("rst_pos", bus.pos, 0);
`endif
        rst = 1'b1;
        model_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ab", ab(), 2'b00);

        // Up, 2 steps, hp 3
        send(1'b1, 2, 3);
        repeat (2) @(negedge clk);
        chk("up_t2", ab(), 2'b00);
        repeat (1) @(negedge clk);
        chk("up_t3", ab(), 2'b10);
        repeat (3) @(negedge clk);
        chk("up_t6", ab(), 2'b11);
        repeat (18) @(negedge clk);
        chk("up_t24", ab(), 2'b00);
        chk("up_done", bus.done, 1);
        repeat (1) @(negedge clk);
        chk("up_ready", bus.cmd_ready, 1);
`ifdef QUAD_POS_EN
        chk("up_pos", bus.pos, 2);
`endif

        // Down, 1 step, hp 0 behaves as 1
        send(1'b0, 1, 0);
        chk("dn_busy", bus.busy, 1);
        repeat (1) @(negedge clk);
        chk("dn_t1", ab(), 2'b01);
        repeat (1) @(negedge clk);
        chk("dn_t2", ab(), 2'b11);
        repeat (1) @(negedge clk);
        chk("dn_t3", ab(), 2'b10);
        repeat (1) @(negedge clk);
        chk("dn_t4", ab(), 2'b00);
        chk("dn_done", bus.done, 1);
`ifdef QUAD_POS_EN
        chk("dn_pos", bus.pos, 1);
`endif

        // Zero steps
        send(1'b1, 0, 5);
        chk("z_done", bus.done, 1);
        chk("z_ab", ab(), 2'b00);
        repeat (1) @(negedge clk);
        chk("z_ready", bus.cmd_ready, 1);

        // Abort after the 5th edge of up 4 steps hp 2
        send(1'b1, 4, 2);
        repeat (10) @(negedge clk);
        chk("ab_t10", ab(), 2'b10);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_done", bus.done, 1);
        chk("ab_hold", ab(), 2'b10);
        repeat (1) @(negedge clk);
        chk("ab_hold2", ab(), 2'b10);
`ifdef QUAD_POS_EN
        chk("ab_pos", bus.pos, 2);
`endif
        send(1'b0, 1, 1);
        repeat (1) @(negedge clk);
        chk("ab_next1", ab(), 2'b00);
        repeat (1) @(negedge clk);
        chk("ab_next2", ab(), 2'b01);
        repeat (1) @(negedge clk);
        chk("ab_next3", ab(), 2'b11);
        repeat (1) @(negedge clk);
        chk("ab_next4", ab(), 2'b10);

        // Reset mid-run after 3 edges
        send(1'b0, 3, 1);
        repeat (3) @(negedge clk);
        chk("mr_t3", ab(), 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("mr_ab", ab(), 2'b00);
        chk("mr_busy", bus.busy, 0);
        chk("mr_ready", bus.cmd_ready, 1);
        chk("mr_done", bus.done, 0);
        #1 rst = 1'b1;
        send(1'b1, 1, 1);
        repeat (1) @(negedge clk);
        chk("mr_next1", ab(), 2'b10);

        // Randomized traffic, including commands offered while busy and aborts
        repeat (3000) begin
            @(negedge clk);
            bus.cmd_valid       = ($urandom % 4) == 0;
            bus.cmd_dir         = 1'($urandom % 2);
            bus.cmd_steps       = CNT_W'($urandom % 5);
            bus.cmd_half_period = DIV_W'($urandom % 4);
            bus.abort           = ($urandom % 20) == 0;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        repeat (120) @(negedge clk);
        chk("end_ready", bus.cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
